rcv_ctrl_fsm: RTL and testbench

//   Receive control unit for the USB RX path; sits directly downstream of the bit timer.

---
 rtl/rcv_ctrl_fsm.sv | 153 +++++++++++++++
 tb/tb_rcv_ctrl_fsm.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/rcv_ctrl_fsm.sv
// USB RX receive control: SYNC validation, payload byte writes, EOP/error tracking.
// Optional first-payload-byte PID check is enabled by defining RCV_PID_CHECK_EN.
module rcv_ctrl_fsm #(
  parameter logic [7:0]  SYNC_BYTE = 8'h80,
  parameter int unsigned MAX_BYTES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       d_edge,
  input  logic       eop,
  input  logic       shift_enable,
  input  logic       byte_received,
  input  logic [7:0] rcv_data,
  output logic       rcving,
  output logic       w_enable,
  output logic [7:0] w_data,
  output logic       r_error,
  output logic [7:0] byte_cnt
);

  localparam logic [7:0] MaxCnt = 8'(MAX_BYTES);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StSync    = 3'd1,
    StRcvByte = 3'd2,
    StEopWait = 3'd3,
    StErrWait = 3'd4,
    StErrEop  = 3'd5,
    StErrIdle = 3'd6
  } state_e;

  state_e     state_q, state_d;
  logic       rcving_q, rcving_d;
  logic       w_enable_q, w_enable_d;
  logic [7:0] w_data_q, w_data_d;
  logic       r_error_q, r_error_d;
  logic [7:0] byte_cnt_q, byte_cnt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       pid_ok;
  logic       eop_sample;

`ifdef RCV_PID_CHECK_EN
  // Only the first payload byte is a PID; later bytes always pass.
  assign pid_ok = (byte_cnt_q != 8'd0) || (rcv_data[7:4] == ~rcv_data[3:0]);
`else
  assign pid_ok = 1'b1;
`endif

  assign eop_sample = eop & shift_enable;

  always_comb begin
    state_d    = state_q;
    rcving_d   = rcving_q;
    w_enable_d = 1'b0;
    w_data_d   = w_data_q;
    r_error_d  = r_error_q;
    byte_cnt_d = byte_cnt_q;
    bit_cnt_d  = bit_cnt_q;

    if (byte_received) begin
      bit_cnt_d = 3'd0;
    end else if (state_q == StRcvByte && shift_enable) begin
      bit_cnt_d = bit_cnt_q + 3'd1;
    end

    case (state_q)
      StIdle, StErrIdle: begin
        if (d_edge) begin
          state_d    = StSync;
          rcving_d   = 1'b1;
          r_error_d  = 1'b0;
          byte_cnt_d = 8'd0;
          bit_cnt_d  = 3'd0;
        end
      end
      StSync: begin
        if (byte_received) begin
          state_d = (rcv_data == SYNC_BYTE) ? StRcvByte : StErrWait;
        end else if (eop_sample) begin
          state_d = StErrEop;
        end
      end
      StRcvByte: begin
        if (byte_received) begin
          if (byte_cnt_q >= MaxCnt || !pid_ok) begin
            state_d = StErrWait;
          end else begin
            w_enable_d = 1'b1;
            w_data_d   = rcv_data;
            byte_cnt_d = byte_cnt_q + 8'd1;
            // A coincident EOP sample still counts as a clean end of packet.
            if (eop_sample) state_d = StEopWait;
          end
        end else if (eop_sample) begin
          state_d = (bit_cnt_q == 3'd0) ? StEopWait : StErrEop;
        end
      end
      StEopWait: begin
        if (d_edge) begin
          state_d  = StIdle;
          rcving_d = 1'b0;
        end
      end
      StErrWait: begin
        if (eop_sample) state_d = StErrEop;
      end
      StErrEop: begin
        if (d_edge) begin
          state_d   = StErrIdle;
          rcving_d  = 1'b0;
          r_error_d = 1'b1;
        end
      end
      default: begin
        state_d    = StIdle;
        rcving_d   = 1'b0;
        w_enable_d = 1'b0;
        w_data_d   = 8'd0;
        r_error_d  = 1'b0;
        byte_cnt_d = 8'd0;
        bit_cnt_d  = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      rcving_q   <= 1'b0;
      w_enable_q <= 1'b0;
      w_data_q   <= 8'd0;
      r_error_q  <= 1'b0;
      byte_cnt_q <= 8'd0;
      bit_cnt_q  <= 3'd0;
    end else begin
      state_q    <= state_d;
      rcving_q   <= rcving_d;
      w_enable_q <= w_enable_d;
      w_data_q   <= w_data_d;
      r_error_q  <= r_error_d;
      byte_cnt_q <= byte_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
    end
  end

  assign rcving   = rcving_q;
  assign w_enable = w_enable_q;
  assign w_data   = w_data_q;
  assign r_error  = r_error_q;
  assign byte_cnt = byte_cnt_q;

endmodule

// File: tb/tb_rcv_ctrl_fsm.sv
// Bench for rcv_ctrl_fsm: packet-level reference model, two instances (MAX_BYTES 64 and 2).
module tb_rcv_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       d_edge = 1'b0;
  logic       eop = 1'b0;
  logic       shift_enable = 1'b0;
  logic       byte_received = 1'b0;
  logic [7:0] rcv_data = 8'd0;

  logic       rcving_a, w_enable_a, r_error_a;
  logic [7:0] w_data_a, byte_cnt_a;
  logic       rcving_b, w_enable_b, r_error_b;
  logic [7:0] w_data_b, byte_cnt_b;

  always #5 clk = ~clk;

  rcv_ctrl_fsm u_dut_a (
    .clk(clk), .rst(rst), .d_edge(d_edge), .eop(eop), .shift_enable(shift_enable),
    .byte_received(byte_received), .rcv_data(rcv_data), .rcving(rcving_a),
    .w_enable(w_enable_a), .w_data(w_data_a), .r_error(r_error_a), .byte_cnt(byte_cnt_a)
  );

  rcv_ctrl_fsm #(.MAX_BYTES(2)) u_dut_b (
    .clk(clk), .rst(rst), .d_edge(d_edge), .eop(eop), .shift_enable(shift_enable),
    .byte_received(byte_received), .rcv_data(rcv_data), .rcving(rcving_b),
    .w_enable(w_enable_b), .w_data(w_data_b), .r_error(r_error_b), .byte_cnt(byte_cnt_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Write monitor: every strobe must follow a byte_received by one cycle and never repeat.
  logic [7:0] wq_a[$];
  logic [7:0] wq_b[$];
  logic       br_prev = 1'b0;
  logic       wen_prev_a = 1'b0;
  logic       wen_prev_b = 1'b0;

  always @(negedge clk) begin
    if (w_enable_a) begin
      check_eq("lat_a", br_prev, 1'b1);
      check_eq("dbl_a", wen_prev_a, 1'b0);
      wq_a.push_back(w_data_a);
    end
    if (w_enable_b) begin
      check_eq("lat_b", br_prev, 1'b1);
      check_eq("dbl_b", wen_prev_b, 1'b0);
      wq_b.push_back(w_data_b);
    end
    br_prev    <= byte_received & ~rst;
    wen_prev_a <= w_enable_a;
    wen_prev_b <= w_enable_b;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic se, input logic ed, input logic eo, input logic br,
                     input logic [7:0] d);
    shift_enable  = se;
    d_edge        = ed;
    eop           = eo;
    byte_received = br;
    rcv_data      = br ? d : 8'($urandom);
    tick();
    shift_enable  = 1'b0;
    d_edge        = 1'b0;
    eop           = 1'b0;
    byte_received = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int nbits, input bit merge_eop);
    for (int i = 0; i < nbits; i++) begin
      cyc(1'b1, ($urandom_range(0, 3) == 0), 1'b0, 1'b0, 8'd0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    end
    if (nbits == 8) begin
      cyc(merge_eop, 1'b0, merge_eop, 1'b1, b);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    end
  endtask

  function automatic bit pid_ok(input logic [7:0] b);
`ifdef RCV_PID_CHECK_EN
    return b[7:4] == ~b[3:0];
`else
    return (b == b);
`endif
  endfunction

  // Payload and expected outcome of one packet; expected writes are always a prefix of pkt.
  logic [7:0] pkt[8];
  int         pkt_n;
  bit         prev_err_a = 1'b0;
  bit         prev_err_b = 1'b0;

  task automatic model(input int maxb, input logic [7:0] sync, input int partial,
                       output int nw, output bit err);
    nw  = 0;
    err = 1'b0;
    if (sync != 8'h80) begin
      err = 1'b1;
    end else begin
      for (int k = 0; k < pkt_n && !err; k++) begin
        if (nw == maxb) err = 1'b1;
        else if (k == 0 && !pid_ok(pkt[0])) err = 1'b1;
        else nw++;
      end
      if (!err && partial != 0) err = 1'b1;
    end
  endtask

  task automatic compare_writes(input string tag, input int nw, input bit is_b);
    int got_n;
    got_n = is_b ? wq_b.size() : wq_a.size();
    check_eq({tag, "_nwr"}, got_n, nw);
    if (got_n == nw) begin
      for (int k = 0; k < nw; k++) begin
        check_eq({tag, "_wdata"}, is_b ? wq_b[k] : wq_a[k], pkt[k]);
      end
    end
  endtask

  task automatic run_packet(input logic [7:0] sync, input int partial, input bit merge);
    int nw_a, nw_b;
    bit err_a, err_b;
    check_eq("err_hold_a", r_error_a, prev_err_a);
    check_eq("err_hold_b", r_error_b, prev_err_b);
    wq_a.delete();
    wq_b.delete();
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    check_eq("start_rcving", rcving_a, 1'b1);
    check_eq("start_err", r_error_b, 1'b0);
    check_eq("start_cnt", byte_cnt_a, 8'd0);
    send_byte(sync, 8, 1'b0);
    for (int k = 0; k < pkt_n; k++) begin
      send_byte(pkt[k], 8, merge && (k == pkt_n - 1) && (partial == 0));
    end
    if (partial != 0) send_byte(8'($urandom), partial, 1'b0);
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    end
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    model(64, sync, partial, nw_a, err_a);
    model(2, sync, partial, nw_b, err_b);
    compare_writes("a", nw_a, 1'b0);
    compare_writes("b", nw_b, 1'b1);
    check_eq("err_a", r_error_a, err_a);
    check_eq("err_b", r_error_b, err_b);
    check_eq("cnt_a", byte_cnt_a, nw_a);
    check_eq("cnt_b", byte_cnt_b, nw_b);
    check_eq("end_rcving_a", rcving_a, 1'b0);
    check_eq("end_rcving_b", rcving_b, 1'b0);
    prev_err_a = err_a;
    prev_err_b = err_b;
  endtask

  initial begin
    logic [3:0] lo;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check_eq("rst_rcving", rcving_a, 1'b0);
    check_eq("rst_wen", w_enable_a, 1'b0);
    check_eq("rst_wdata", w_data_a, 8'd0);
    check_eq("rst_err", r_error_a, 1'b0);
    check_eq("rst_cnt", byte_cnt_b, 8'd0);
    rst = 1'b0;
    for (int i = 0; i < 50; i++) tick();
    check_eq("idle_rcving", rcving_a, 1'b0);
    check_eq("idle_wen", w_enable_b, 1'b0);
    check_eq("idle_err", r_error_a, 1'b0);

    pkt[0] = 8'hC3; pkt[1] = 8'h12; pkt[2] = 8'h34; pkt_n = 3;
    run_packet(8'h80, 0, 1'b0);
    pkt_n = 0;
    run_packet(8'h81, 0, 1'b0);
    pkt[0] = 8'hC3; pkt_n = 1;
    run_packet(8'h80, 4, 1'b0);
    pkt[0] = 8'hC4; pkt[1] = 8'h55; pkt_n = 2;
    run_packet(8'h80, 0, 1'b0);
    pkt[0] = 8'hC3; pkt[1] = 8'h0A; pkt_n = 2;
    run_packet(8'h80, 0, 1'b1);

    // Reset lands on the same edge as a byte strobe: nothing may be written.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    send_byte(8'h80, 8, 1'b0);
    send_byte(8'h00, 7, 1'b0);
    rst = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 8'h5A);
    rst = 1'b0;
    check_eq("rst_mid_wen", w_enable_a, 1'b0);
    check_eq("rst_mid_rcving", rcving_a, 1'b0);
    check_eq("rst_mid_cnt", byte_cnt_a, 8'd0);
    check_eq("rst_mid_err", r_error_b, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    prev_err_a = 1'b0;
    prev_err_b = 1'b0;

    for (int p = 0; p < 40; p++) begin
      pkt_n = $urandom_range(0, 4);
      for (int k = 0; k < pkt_n; k++) pkt[k] = 8'($urandom);
      lo = 4'($urandom);
      if ($urandom_range(0, 9) < 7) pkt[0] = {~lo, lo};
      run_packet(($urandom_range(0, 99) < 85) ? 8'h80 : 8'($urandom),
                 ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0,
                 ($urandom_range(0, 9) < 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
